// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front end for a word-wide synchronous data memory.
// Sub-word stores become read-modify-write; stall holds the datapath while an access is in flight.
// Optional feature macro: LSU_MMIO_EN (addresses >= MMIO_BASE hit an internal mmio_out register).
module load_store_unit #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    input  logic [31:0]       mem_q,
    output logic [31:0]       mmio_out
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_READ, RMW_WRITE} state_t;

    state_t            state, state_nxt;
    logic              legal_c, accept_c, fault_nxt_c, is_sw_c, is_mmio_c;
    logic [2:0]        lat_f3;
    logic [1:0]        lat_lane;
    logic [ADDR_W-1:0] lat_waddr;
    logic [15:0]       lat_wdata;
    logic              lat_mmio;
    logic [31:0]       wdata_q;
    logic [31:0]       mmio_q;

    // Select the byte/half lane of a word and sign- or zero-extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lane);
        logic [31:0] sh;
        sh = w >> {lane, 3'b000};
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Replace one byte/half lane of a word with store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [15:0] d,
                                               input logic half, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] data;
        mask = (half ? 32'h0000_FFFF : 32'h0000_00FF) << {lane, 3'b000};
        data = {16'b0, d} << {lane, 3'b000};
        return (w & ~mask) | (data & mask);
    endfunction

    // Request decode: funct3 legality, alignment, store kind, MMIO window.
    always_comb begin
        logic f3_ok;
        logic align_ok;
        if (req_write) f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else           f3_ok = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
        case (req_funct3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = !req_addr[0];
            default: align_ok = (req_addr[1:0] == 2'b00);
        endcase
        legal_c     = f3_ok && align_ok;
        accept_c    = !rst && (state == IDLE) && req_valid && legal_c;
        fault_nxt_c = !rst && (state == IDLE) && req_valid && !legal_c;
        is_sw_c     = req_write && (req_funct3[1:0] == 2'b10);
`ifdef LSU_MMIO_EN
        is_mmio_c   = (req_addr >= MMIO_BASE);
`else
        is_mmio_c   = 1'b0;
`endif
    end

`ifndef LSU_MMIO_EN
    logic unused_c;
    assign unused_c = ^{req_addr[31:ADDR_W+2], MMIO_BASE};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and memory-side/load-return outputs.
    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        mem_wren    = 1'b0;
        mem_addr    = lat_waddr;
        mem_data    = wdata_q;
        rdata       = 32'b0;
        rdata_valid = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    mem_addr = req_addr[ADDR_W+1:2];
                    if (accept_c) begin
                        if (!req_write) begin
                            stall     = 1'b1;
                            state_nxt = LOAD_WAIT;
                        end else if (is_mmio_c) begin
                            state_nxt = IDLE;
                        end else if (is_sw_c) begin
                            mem_wren = 1'b1;
                            mem_data = req_wdata;
                        end else begin
                            stall     = 1'b1;
                            state_nxt = RMW_READ;
                        end
                    end
                end
                LOAD_WAIT: begin
                    rdata       = load_ext(lat_mmio ? mmio_q : mem_q, lat_f3, lat_lane);
                    rdata_valid = 1'b1;
                    state_nxt   = IDLE;
                end
                RMW_READ: begin
                    stall     = 1'b1;
                    state_nxt = RMW_WRITE;
                end
                RMW_WRITE: begin
                    mem_wren  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Request latch, fault pulse, merged write word and MMIO register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault     <= 1'b0;
            lat_f3    <= 3'b0;
            lat_lane  <= 2'b0;
            lat_waddr <= '0;
            lat_wdata <= 16'b0;
            lat_mmio  <= 1'b0;
            wdata_q   <= 32'b0;
            mmio_q    <= 32'b0;
        end else begin
            fault <= fault_nxt_c;
            if (accept_c) begin
                lat_f3    <= req_funct3;
                lat_lane  <= req_addr[1:0];
                lat_waddr <= req_addr[ADDR_W+1:2];
                lat_wdata <= req_wdata[15:0];
                lat_mmio  <= is_mmio_c;
            end
            if (state == RMW_READ)
                wdata_q <= lane_merge(mem_q, lat_wdata, lat_f3[0], lat_lane);
`ifdef LSU_MMIO_EN
            if (accept_c && req_write && is_mmio_c)
                mmio_q <= is_sw_c ? req_wdata : lane_merge(mmio_q, req_wdata[15:0], req_funct3[0], req_addr[1:0]);
`endif
        end
    end

    assign mmio_out = mmio_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-in-RMW sequence, random ops vs a byte-array model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rdata_valid, fault, mem_wren;
    logic [31:0] rdata, mem_data, mem_q, mmio_out;
    logic [7:0]  mem_addr;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .mmio_out(mmio_out)
    );

    always #5 clk = ~clk;

    // Synchronous 1-cycle-latency data memory.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'b0;
        mem_q = 32'b0;
    end
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: flat byte-addressed 1 KB memory.
    logic [7:0] ref_mem [1024];

    function automatic bit ref_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int n;
        if (wr && f3 > 2) return 0;
        if (!wr && (f3 == 3 || f3 > 5)) return 0;
        n = 1 << f3[1:0];
        return (a % n) == 0;
    endfunction

    task automatic model_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input bit to_mem,
                            output int e_stall, output int e_wren, output int e_rv, output int e_fault,
                            output logic [31:0] e_rdata, output logic [31:0] e_word);
        int n;
        logic [31:0] v;
        int base;
        e_stall = 0; e_wren = 0; e_rv = 0; e_fault = 0; e_rdata = 0; e_word = 0;
        n = 1 << f3[1:0];
        if (!ref_legal(wr, f3, a)) begin
            e_fault = 1;
            return;
        end
        base = int'(a & 32'h3FC);
        if (wr) begin
            if (to_mem) for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) & 1023] = wd[8*i +: 8];
            e_stall = (n == 4) ? 0 : 2;
            e_wren  = to_mem ? 1 : 0;
            for (int i = 0; i < 4; i++) e_word[8*i +: 8] = ref_mem[base + i];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) & 1023];
            if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
            e_stall = 1; e_rv = 1; e_rdata = v;
        end
    endtask

    // Observation accumulators for one operation.
    int          s_stall, s_wren, s_rv, s_fault;
    logic [31:0] s_rd, s_wa, s_wd;
    logic        s_tout;

    task automatic sample_outputs();
        if (stall) s_stall++;
        if (mem_wren) begin s_wren++; s_wa = 32'(mem_addr); s_wd = mem_data; end
        if (rdata_valid) begin s_rv++; s_rd = rdata; end
        if (fault) s_fault++;
    endtask

    // Issue one request, hold it while stalled, then watch one more cycle for the fault pulse.
    task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit done;
        s_stall = 0; s_wren = 0; s_rv = 0; s_fault = 0; s_rd = 0; s_wa = 0; s_wd = 0;
        done = 0;
        @(posedge clk); #1;
        req_valid = 1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            sample_outputs();
            if (!stall) done = 1;
            @(posedge clk); #1;
        end
        req_valid = 0;
        s_tout = !done;
        @(negedge clk);
        sample_outputs();
    endtask

    task automatic compare_op(input string tag, input int e_stall, input int e_wren, input int e_rv,
                              input int e_fault, input logic [31:0] e_rdata,
                              input logic [31:0] e_wa, input logic [31:0] e_wd);
        check({tag, " timeout"}, 32'(s_tout), 32'd0);
        check({tag, " stall_cycles"}, 32'(s_stall), 32'(e_stall));
        check({tag, " wren_pulses"}, 32'(s_wren), 32'(e_wren));
        check({tag, " rdata_valid_pulses"}, 32'(s_rv), 32'(e_rv));
        check({tag, " fault_pulses"}, 32'(s_fault), 32'(e_fault));
        if (e_rv > 0) check({tag, " rdata"}, s_rd, e_rdata);
        if (e_wren > 0) begin
            check({tag, " mem_addr"}, s_wa, e_wa);
            check({tag, " mem_data"}, s_wd, e_wd);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          e_stall, e_wren, e_rv, e_fault;
        logic [31:0] e_rdata, e_wa, e_wd;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int es, input int ew, input int er,
                                input int ef, input logic [31:0] erd, input logic [31:0] ewa,
                                input logic [31:0] ewd);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.e_stall = es; v.e_wren = ew; v.e_rv = er; v.e_fault = ef;
        v.e_rdata = erd; v.e_wa = ewa; v.e_wd = ewd;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int          es, ew, er, ef;
        logic [31:0] erd, ewd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        bit          mmio_hit;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;

        //            wr  f3    addr          wdata          stl wr rv ft  rdata          waddr  wdata
        tbl.push_back(mk(1, 3'd2, 32'h10,  32'hDEADBEEF, 0, 1, 0, 0, 32'h0,         32'd4, 32'hDEADBEEF));
        tbl.push_back(mk(0, 3'd0, 32'h13,  32'h0,        1, 0, 1, 0, 32'hFFFFFFDE,  32'd0, 32'h0));
        tbl.push_back(mk(0, 3'd4, 32'h13,  32'h0,        1, 0, 1, 0, 32'h000000DE,  32'd0, 32'h0));
        tbl.push_back(mk(1, 3'd1, 32'h12,  32'h00001234, 2, 1, 0, 0, 32'h0,         32'd4, 32'h1234BEEF));
        tbl.push_back(mk(0, 3'd2, 32'h10,  32'h0,        1, 0, 1, 0, 32'h1234BEEF,  32'd0, 32'h0));
        tbl.push_back(mk(0, 3'd2, 32'h11,  32'h0,        0, 0, 0, 1, 32'h0,         32'd0, 32'h0));
        tbl.push_back(mk(0, 3'd3, 32'h10,  32'h0,        0, 0, 0, 1, 32'h0,         32'd0, 32'h0));
        tbl.push_back(mk(1, 3'd3, 32'h10,  32'h55555555, 0, 0, 0, 1, 32'h0,         32'd0, 32'h0));
        tbl.push_back(mk(1, 3'd2, 32'h12,  32'h66666666, 0, 0, 0, 1, 32'h0,         32'd0, 32'h0));
        tbl.push_back(mk(1, 3'd0, 32'h11,  32'hFFFFFFAB, 2, 1, 0, 0, 32'h0,         32'd4, 32'h1234ABEF));
        tbl.push_back(mk(0, 3'd1, 32'h12,  32'h0,        1, 0, 1, 0, 32'h00001234,  32'd0, 32'h0));
        tbl.push_back(mk(0, 3'd1, 32'h10,  32'h0,        1, 0, 1, 0, 32'hFFFFABEF,  32'd0, 32'h0));
        tbl.push_back(mk(0, 3'd5, 32'h10,  32'h0,        1, 0, 1, 0, 32'h0000ABEF,  32'd0, 32'h0));
        tbl.push_back(mk(0, 3'd1, 32'h13,  32'h0,        0, 0, 0, 1, 32'h0,         32'd0, 32'h0));
        tbl.push_back(mk(0, 3'd7, 32'h10,  32'h0,        0, 0, 0, 1, 32'h0,         32'd0, 32'h0));
        tbl.push_back(mk(0, 3'd2, 32'h3FC, 32'h0,        1, 0, 1, 0, 32'h0,         32'd0, 32'h0));
`ifdef LSU_MMIO_EN
        tbl.push_back(mk(1, 3'd2, 32'h400, 32'h000000A5, 0, 0, 0, 0, 32'h0,         32'd0, 32'h0));
        tbl.push_back(mk(0, 3'd2, 32'h400, 32'h0,        1, 0, 1, 0, 32'h000000A5,  32'd0, 32'h0));
        tbl.push_back(mk(1, 3'd0, 32'h401, 32'h0000003C, 0, 0, 0, 0, 32'h0,         32'd0, 32'h0));
        tbl.push_back(mk(0, 3'd1, 32'h400, 32'h0,        1, 0, 1, 0, 32'h00003CA5,  32'd0, 32'h0));
`else
        tbl.push_back(mk(1, 3'd2, 32'h400, 32'h000000A5, 0, 1, 0, 0, 32'h0,         32'd0, 32'h000000A5));
        tbl.push_back(mk(0, 3'd2, 32'h0,   32'h0,        1, 0, 1, 0, 32'h000000A5,  32'd0, 32'h0));
`endif

        // Reset for two cycles, then check idle output values.
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset rdata", rdata, 32'h0);
        check("reset rdata_valid", 32'(rdata_valid), 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        check("reset mem_wren", 32'(mem_wren), 32'd0);
        check("reset mem_data", mem_data, 32'h0);
        check("reset mmio_out", mmio_out, 32'h0);

        // Directed vectors; stores also update the byte model so later random loads agree.
        foreach (tbl[i]) begin
            do_op(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
            compare_op($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_wren, tbl[i].e_rv,
                       tbl[i].e_fault, tbl[i].e_rdata, tbl[i].e_wa, tbl[i].e_wd);
`ifdef LSU_MMIO_EN
            mmio_hit = (tbl[i].addr >= 32'h400);
`else
            mmio_hit = 0;
`endif
            model_op(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, !mmio_hit, es, ew, er, ef, erd, ewd);
        end
`ifdef LSU_MMIO_EN
        check("mmio_out after stores", mmio_out, 32'h00003CA5);
`else
        check("mmio_out tied", mmio_out, 32'h0);
`endif

        // Reset while an SB sits in the read half of its read-modify-write.
        @(posedge clk); #1;
        req_valid = 1; req_write = 1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h77;
        @(negedge clk);
        check("rmw_rst accept stall", 32'(stall), 32'd1);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        check("rmw_rst wren during rst", 32'(mem_wren), 32'd0);
        @(posedge clk); #1 rst = 0; req_valid = 0;
        @(negedge clk);
        check("rmw_rst stall", 32'(stall), 32'd0);
        check("rmw_rst wren", 32'(mem_wren), 32'd0);
        check("rmw_rst mem_data", mem_data, 32'h0);
        check("rmw_rst rdata_valid", 32'(rdata_valid), 32'd0);
        check("rmw_rst rdata", rdata, 32'h0);
        check("rmw_rst fault", 32'(fault), 32'd0);
        @(negedge clk);
        check("rmw_rst wren later", 32'(mem_wren), 32'd0);
        model_op(0, 3'd2, 32'h10, 32'h0, 1, es, ew, er, ef, erd, ewd);
        do_op(0, 3'd2, 32'h10, 32'h0);
        compare_op("rmw_rst reload", es, ew, er, ef, erd, 32'd0, 32'h0);

        // Random traffic against the byte model (memory window only).
        for (int n = 0; n < 200; n++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            else                          f3 = 3'($urandom_range(0, 7));
            if (f3 == 3'd3 && !wr) f3 = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'd2;
            a = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(0, 3));
            else if (f3[1:0] == 2'b00) a = a | 32'($urandom_range(0, 3));
            else if (f3[1:0] == 2'b01) a = a | (32'($urandom_range(0, 1)) << 1);
            wd = $urandom;
            model_op(wr, f3, a, wd, 1, es, ew, er, ef, erd, ewd);
            do_op(wr, f3, a, wd);
            compare_op($sformatf("rnd%0d", n), es, ew, er, ef, erd, (a >> 2) & 32'hFF, ewd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
